// File: rtl/life_gen_sequencer.sv
// Serial Game of Life generation engine: double-buffered grid, one cell per clock.
// Define LIFE_TORUS_EN for a toroidal grid; default build treats off-grid cells as dead.
module life_gen_sequencer #(
    parameter int GRID_W         = 16,
    parameter int GRID_H         = 16,
    parameter int IDX_W          = 8,
    parameter int FRAMES_PER_GEN = 60,
    parameter int GEN_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             run,
    input  logic             step_req,
    input  logic             seed_we,
    input  logic [IDX_W-1:0] seed_idx,
    input  logic             seed_val,
    input  logic             seed_clear,
    input  logic [IDX_W-1:0] disp_idx,
    output logic             disp_cell,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int FC_W  = $clog2(FRAMES_PER_GEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        SWAP
    } state_t;

    state_t           state_q;
    logic [NCELL-1:0] bank_q [2];
    logic             bank_sel_q;
    logic [IDX_W-1:0] idx_q;
    logic [FC_W-1:0]  frame_cnt_q;
    logic             pending_q;
    logic             busy_q;
    logic             gen_done_q;
    logic [GEN_W-1:0] gen_count_q;

    logic [NCELL-1:0] active;
    logic [3:0]       n_cnt;
    logic             next_cell;
    logic             launch;
    logic             tick_wrap;
    int               nr;
    int               nc;
    logic             nb_ok;
    logic [IDX_W-1:0] nidx;

    assign active    = bank_q[bank_sel_q];
    assign disp_cell = active[disp_idx];
    assign busy      = busy_q;
    assign gen_done  = gen_done_q;
    assign gen_count = gen_count_q;

    assign launch    = (state_q == IDLE) && (pending_q || step_req);
    assign tick_wrap = frame_tick && (frame_cnt_q == FC_W'(FRAMES_PER_GEN - 1));

    // Neighbour count for the cell currently being computed
    always_comb begin
        n_cnt = 4'd0;
        nr    = 0;
        nc    = 0;
        nb_ok = 1'b0;
        nidx  = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (!(dx == 0 && dy == 0)) begin
                    nr = int'(idx_q) / GRID_W + dy;
                    nc = int'(idx_q) % GRID_W + dx;
`ifdef LIFE_TORUS_EN
                    nr    = nr & (GRID_H - 1);
                    nc    = nc & (GRID_W - 1);
                    nb_ok = 1'b1;
`else
                    nb_ok = (nr >= 0) && (nr < GRID_H) &&
                            (nc >= 0) && (nc < GRID_W);
`endif
                    nidx = IDX_W'(nr * GRID_W + nc);
                    if (nb_ok && active[nidx]) begin
                        n_cnt = n_cnt + 4'd1;
                    end
                end
            end
        end
        next_cell = (n_cnt == 4'd3) | (active[idx_q] & (n_cnt == 4'd2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            bank_sel_q  <= 1'b0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            gen_done_q <= 1'b0;

            // A tick landing on the launch cycle re-arms pending
            if (!run) begin
                frame_cnt_q <= '0;
                pending_q   <= 1'b0;
            end else begin
                if (launch) begin
                    pending_q <= 1'b0;
                end
                if (tick_wrap) begin
                    frame_cnt_q <= '0;
                    pending_q   <= 1'b1;
                end else if (frame_tick) begin
                    frame_cnt_q <= frame_cnt_q + FC_W'(1);
                end
            end

            unique case (state_q)
                IDLE: begin
                    if (seed_clear) begin
                        bank_q[bank_sel_q] <= '0;
                    end else if (seed_we) begin
                        bank_q[bank_sel_q][seed_idx] <= seed_val;
                    end
                    if (launch) begin
                        state_q <= COMPUTE;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    bank_q[~bank_sel_q][idx_q] <= next_cell;
                    if (idx_q == IDX_W'(NCELL - 1)) begin
                        state_q <= SWAP;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                SWAP: begin
                    bank_sel_q  <= ~bank_sel_q;
                    gen_count_q <= gen_count_q + GEN_W'(1);
                    gen_done_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed self-checking bench for life_gen_sequencer (FRAMES_PER_GEN=4).
// Expected grids follow LIFE_TORUS_EN when the bench is built with it.
module tb_life_gen_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        run;
    logic        step_req;
    logic        seed_we;
    logic [7:0]  seed_idx;
    logic        seed_val;
    logic        seed_clear;
    logic [7:0]  disp_idx;
    logic        disp_cell;
    logic        busy;
    logic        gen_done;
    logic [15:0] gen_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    life_gen_sequencer #(
        .GRID_W(16), .GRID_H(16), .IDX_W(8),
        .FRAMES_PER_GEN(4), .GEN_W(16)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run),
        .step_req(step_req), .seed_we(seed_we), .seed_idx(seed_idx),
        .seed_val(seed_val), .seed_clear(seed_clear), .disp_idx(disp_idx),
        .disp_cell(disp_cell), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count)
    );

    task automatic do_reset();
        reset = 1'b1;
        frame_tick = 0; run = 0; step_req = 0; seed_we = 0;
        seed_idx = 0; seed_val = 0; seed_clear = 0; disp_idx = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic seed(input logic [7:0] idx);
        seed_we = 1'b1; seed_idx = idx; seed_val = 1'b1;
        @(posedge clk); #1;
        seed_we = 1'b0;
    endtask

    task automatic step();
        step_req = 1'b1;
        @(posedge clk); #1;
        step_req = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic read_grid(output logic [255:0] g);
        g = '0;
        for (int i = 0; i < 256; i++) begin
            disp_idx = 8'(i);
            #1;
            g[i] = disp_cell;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_gen(output int cyc, output int pulses);
        cyc = 0; pulses = 0;
        while (busy && cyc < 400) begin
            cyc++;
            if (gen_done) pulses++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [255:0] g;
        int pulses;
        do_reset();
        pulses = 0;
        repeat (10) begin
            if (gen_done) pulses++;
            @(posedge clk); #1;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL reset_gen_done got %0d want 0", pulses);
        end
        tests++;
        if (gen_count !== 16'd0) begin
            fails++; $display("FAIL reset_gen_count got %0d want 0", gen_count);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy got %b want 0", busy);
        end
        read_grid(g);
        tests++;
        if (g !== '0) begin
            fails++; $display("FAIL reset_grid got %h want 0", g);
        end
    endtask

    task automatic test_blinker();
        logic [255:0] g, e;
        int cyc, pulses;
        do_reset();
        seed(17); seed(18); seed(19);
        step();
        wait_gen(cyc, pulses);
        tests++;
        if (cyc !== 257) begin
            fails++; $display("FAIL blink_busy_len got %0d want 257", cyc);
        end
        tests++;
        if (pulses !== 0 || gen_done !== 1'b1) begin
            fails++; $display("FAIL blink_done_at_end got %0d/%b want 0/1", pulses, gen_done);
        end
        @(posedge clk); #1;
        tests++;
        if (gen_done !== 1'b0) begin
            fails++; $display("FAIL blink_done_width got %b want 0", gen_done);
        end
        tests++;
        if (gen_count !== 16'd1) begin
            fails++; $display("FAIL blink_count1 got %0d want 1", gen_count);
        end
        read_grid(g);
        e = '0; e[2] = 1; e[18] = 1; e[34] = 1;
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL blink_gen1 got %h want %h", g, e);
        end
        step();
        wait_gen(cyc, pulses);
        @(posedge clk); #1;
        tests++;
        if (gen_count !== 16'd2) begin
            fails++; $display("FAIL blink_count2 got %0d want 2", gen_count);
        end
        read_grid(g);
        e = '0; e[17] = 1; e[18] = 1; e[19] = 1;
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL blink_gen2 got %h want %h", g, e);
        end
    endtask

    task automatic test_block();
        logic [255:0] g, e;
        int cyc, pulses;
        do_reset();
        seed(0); seed(1); seed(16);
        step();
        wait_gen(cyc, pulses);
        read_grid(g);
        e = '0; e[0] = 1; e[1] = 1; e[16] = 1; e[17] = 1;
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL block_gen1 got %h want %h", g, e);
        end
        step();
        wait_gen(cyc, pulses);
        read_grid(g);
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL block_gen2 got %h want %h", g, e);
        end
        tests++;
        if (gen_count !== 16'd2) begin
            fails++; $display("FAIL block_count got %0d want 2", gen_count);
        end
    endtask

    task automatic test_frames();
        logic [255:0] g, e;
        int pulses, busy_seen;
        do_reset();
        seed(17); seed(18); seed(19);
        run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            pulses = 0;
            repeat (299) begin
                if (gen_done) pulses++;
                @(posedge clk); #1;
            end
            tests++;
            if (pulses !== ((i % 4 == 0) ? 1 : 0) || gen_count !== 16'(i / 4)) begin
                fails++;
                $display("FAIL frames_tick%0d got pulses=%0d count=%0d want %0d/%0d",
                         i, pulses, gen_count, (i % 4 == 0) ? 1 : 0, i / 4);
            end
        end
        run = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            repeat (20) begin
                if (busy) busy_seen++;
                @(posedge clk); #1;
            end
        end
        tests++;
        if (gen_count !== 16'd2 || busy_seen !== 0) begin
            fails++; $display("FAIL frames_run_off got count=%0d busy=%0d want 2/0",
                              gen_count, busy_seen);
        end
        read_grid(g);
        e = '0; e[17] = 1; e[18] = 1; e[19] = 1;
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL frames_grid got %h want %h", g, e);
        end
    endtask

    task automatic test_busy_ignore();
        logic [255:0] g, e;
        int c, bad;
        do_reset();
        seed(17); seed(18); seed(19);
        disp_idx = 8'd17;
        step();
        c = 0; bad = 0;
        while (busy && c < 400) begin
            if (disp_cell !== 1'b1) bad++;
            c++;
            @(posedge clk); #1;
            seed_we    = (c == 10);
            seed_idx   = 8'd100;
            seed_val   = 1'b1;
            seed_clear = (c == 11);
            step_req   = (c == 12);
        end
        seed_we = 0; seed_clear = 0; step_req = 0;
        tests++;
        if (c !== 257 || bad !== 0) begin
            fails++; $display("FAIL busy_disp_hold got len=%0d bad=%0d want 257/0", c, bad);
        end
        tests++;
        if (gen_done !== 1'b1 || disp_cell !== 1'b0) begin
            fails++; $display("FAIL busy_disp_swap got done=%b cell=%b want 1/0",
                              gen_done, disp_cell);
        end
        repeat (300) @(posedge clk);
        #1;
        tests++;
        if (gen_count !== 16'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL busy_step_ignored got count=%0d busy=%b want 1/0",
                              gen_count, busy);
        end
        read_grid(g);
        e = '0; e[2] = 1; e[18] = 1; e[34] = 1;
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL busy_seed_ignored got %h want %h", g, e);
        end
    endtask

    task automatic test_edges();
        logic [255:0] g, e;
        int cyc, pulses;
        do_reset();
        seed(15); seed(0); seed(1);
        step();
        wait_gen(cyc, pulses);
        read_grid(g);
        e = '0;
`ifdef LIFE_TORUS_EN
        e[240] = 1; e[0] = 1; e[16] = 1;
`endif
        tests++;
        if (g !== e) begin
            fails++; $display("FAIL edge_wrap got %h want %h", g, e);
        end
        tests++;
        if (gen_count !== 16'd1) begin
            fails++; $display("FAIL edge_count got %0d want 1", gen_count);
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_frames();
        test_busy_ignore();
        test_edges();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
